mac_acc_buffer: RTL and testbench

//  Accumulator side of the MAC result interface. Drives the running partial sum into MAC.acc_dat_i.

---
 rtl/mac_acc_buffer_pkg.sv | 17 +
 rtl/mac_acc_buffer_if.sv | 17 +
 rtl/mac_acc_buffer_regfile.sv | 20 ++
 rtl/mac_acc_buffer.sv | 150 +++++++++++++++
 tb/tb_mac_acc_buffer.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_acc_buffer_pkg.sv
// Shared types for the MAC accumulator buffer: FSM states, result width and default depth.
`ifndef OUTPUT_BUF_SIZE
`define OUTPUT_BUF_SIZE 32
`endif

package npu_acc_pkg;
  localparam int ACC_W       = `OUTPUT_BUF_SIZE;
  localparam int MAX_OUT_DEF = 16;

  typedef logic [ACC_W-1:0] acc_dat_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } acc_state_e;
endpackage

// File: rtl/mac_acc_buffer_if.sv
// Result-store access bundle: one write port and one combinational read port.
import npu_acc_pkg::*;

interface mac_acc_buffer_if #(
  parameter int DEPTH = MAX_OUT_DEF
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  acc_dat_t         wr_dat;
  logic [IDX_W-1:0] rd_idx;
  acc_dat_t         rd_dat;

  modport master (output wr_en, output wr_idx, output wr_dat, output rd_idx, input rd_dat);
  modport slave  (input wr_en, input wr_idx, input wr_dat, input rd_idx, output rd_dat);
endinterface

// File: rtl/mac_acc_buffer_regfile.sv
// Result store: DEPTH entries, one synchronous write, one combinational read.
import npu_acc_pkg::*;

module acc_res_regfile #(
  parameter int DEPTH = MAX_OUT_DEF
) (
  input logic              clk_i,
  mac_acc_buffer_if.slave  rf
);
  acc_dat_t mem [DEPTH];

  // Contents are left unreset; the read side only reaches entries written in the current job.
  always_ff @(posedge clk_i) begin
    if (rf.wr_en) begin
      mem[rf.wr_idx] <= rf.wr_dat;
    end
  end

  assign rf.rd_dat = mem[rf.rd_idx];
endmodule

// File: rtl/mac_acc_buffer.sv
// Accumulator side of the MAC: feeds the running partial sum back, retires a result every
// k_len beats, and streams n_out results to the output stage over valid/ready.
import npu_acc_pkg::*;

module mac_acc_buffer #(
  parameter int MAX_OUT = MAX_OUT_DEF,
  parameter int K_W     = 16,
  parameter int N_W     = $clog2(MAX_OUT) + 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
  input  logic [K_W-1:0] cfg_k_len_i,
  input  logic [N_W-1:0] cfg_n_out_i,
  input  logic           mac_val_i,
  input  acc_dat_t       mac_sum_i,
  output acc_dat_t       mac_acc_o,
  output logic           busy_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output acc_dat_t       out_dat_o,
  output logic           out_last_o,
  output logic           done_o,
  output logic           err_o
);
  localparam int             IDX_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [N_W-1:0] MAX_N = N_W'(MAX_OUT);
  localparam logic [N_W-1:0] ONE_N = N_W'(1);
  localparam logic [K_W-1:0] ONE_K = K_W'(1);

  acc_state_e     state_reg, state_next;
  acc_dat_t       acc_run_reg, acc_run_next;
  logic [K_W-1:0] k_cnt_reg, k_cnt_next;
  logic [K_W-1:0] k_len_reg, k_len_next;
  logic [N_W-1:0] n_out_reg, n_out_next;
  logic [N_W-1:0] wr_idx_reg, wr_idx_next;
  logic [N_W-1:0] rd_idx_reg, rd_idx_next;
  logic           done_reg, done_next;
  logic           err_reg, err_next;
  logic           wr_en;
  logic [N_W-1:0] n_cfg;

  mac_acc_buffer_if #(.DEPTH(MAX_OUT)) rf_bus ();

  acc_res_regfile #(.DEPTH(MAX_OUT)) u_regfile (
    .clk_i (clk_i),
    .rf    (rf_bus.slave)
  );

  assign rf_bus.wr_en  = wr_en;
  assign rf_bus.wr_idx = wr_idx_reg[IDX_W-1:0];
  assign rf_bus.wr_dat = mac_sum_i;
  assign rf_bus.rd_idx = rd_idx_reg[IDX_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg   <= ST_IDLE;
      acc_run_reg <= '0;
      k_cnt_reg   <= '0;
      k_len_reg   <= '0;
      n_out_reg   <= '0;
      wr_idx_reg  <= '0;
      rd_idx_reg  <= '0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_run_reg <= acc_run_next;
      k_cnt_reg   <= k_cnt_next;
      k_len_reg   <= k_len_next;
      n_out_reg   <= n_out_next;
      wr_idx_reg  <= wr_idx_next;
      rd_idx_reg  <= rd_idx_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_run_next = acc_run_reg;
    k_cnt_next   = k_cnt_reg;
    k_len_next   = k_len_reg;
    n_out_next   = n_out_reg;
    wr_idx_next  = wr_idx_reg;
    rd_idx_next  = rd_idx_reg;
    done_next    = 1'b0;
    err_next     = err_reg;
    wr_en        = 1'b0;
    n_cfg        = (cfg_n_out_i > MAX_N) ? MAX_N : cfg_n_out_i;

    // A beat the FSM cannot use is a protocol error; an accepted start below still clears it.
    if (mac_val_i && (state_reg != ST_ACCUM)) begin
      err_next = 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          k_len_next   = (cfg_k_len_i == '0) ? ONE_K : cfg_k_len_i;
          n_out_next   = n_cfg;
          acc_run_next = '0;
          k_cnt_next   = '0;
          wr_idx_next  = '0;
          err_next     = 1'b0;
          if (n_cfg == '0) begin
            done_next = 1'b1;
          end else begin
            state_next = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (mac_val_i) begin
          if (k_cnt_reg == k_len_reg - ONE_K) begin
            wr_en        = 1'b1;
            acc_run_next = '0;
            k_cnt_next   = '0;
            wr_idx_next  = wr_idx_reg + ONE_N;
            if (wr_idx_reg == n_out_reg - ONE_N) begin
              state_next  = ST_DRAIN;
              rd_idx_next = '0;
            end
          end else begin
            acc_run_next = mac_sum_i;
            k_cnt_next   = k_cnt_reg + ONE_K;
          end
        end
      end
      ST_DRAIN: begin
        if (out_ready_i) begin
          rd_idx_next = rd_idx_reg + ONE_N;
          if (rd_idx_reg == n_out_reg - ONE_N) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign mac_acc_o   = (state_reg == ST_ACCUM) ? acc_run_reg : '0;
  assign busy_o      = (state_reg == ST_ACCUM) || (state_reg == ST_DRAIN);
  assign out_valid_o = (state_reg == ST_DRAIN);
  assign out_dat_o   = out_valid_o ? rf_bus.rd_dat : '0;
  assign out_last_o  = out_valid_o && (rd_idx_reg == n_out_reg - ONE_N);
  assign done_o      = done_reg;
  assign err_o       = err_reg;
endmodule

// File: tb/tb_mac_acc_buffer.sv
// Directed bench: a behavioural MAC sits in front of the buffer; a scoreboard checks the result stream.
import npu_acc_pkg::*;

module tb_mac_acc_buffer;
  localparam int MAX_OUT = 16;
  localparam int K_W     = 16;
  localparam int N_W     = $clog2(MAX_OUT) + 1;

  typedef struct {
    acc_dat_t dat;
    logic     last;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [K_W-1:0] cfg_k = '0;
  logic [N_W-1:0] cfg_n = '0;
  logic           mac_val = 1'b0;
  acc_dat_t       prod = '0;
  acc_dat_t       mac_sum;
  acc_dat_t       mac_acc;
  logic           busy, out_valid, out_ready, out_last, done, err;
  acc_dat_t       out_dat;

  int   total = 0;
  int   bad = 0;
  int   hs_cnt = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  // MAC model: adds the product to the partial sum the buffer feeds back.
  assign mac_sum = mac_acc + prod;

  mac_acc_buffer #(.MAX_OUT(MAX_OUT), .K_W(K_W), .N_W(N_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .cfg_k_len_i (cfg_k),
    .cfg_n_out_i (cfg_n),
    .mac_val_i   (mac_val),
    .mac_sum_i   (mac_sum),
    .mac_acc_o   (mac_acc),
    .busy_o      (busy),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_dat_o   (out_dat),
    .out_last_o  (out_last),
    .done_o      (done),
    .err_o       (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Scoreboard monitor: samples mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst && out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL out_unexpected: got dat=%0d last=%0d expected no result", out_dat, out_last);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (out_dat !== e.dat || out_last !== e.last) begin
          bad++;
          $display("FAIL out_result: got dat=%0d last=%0d expected dat=%0d last=%0d",
                   out_dat, out_last, e.dat, e.last);
        end else begin
          $display("ok   out_result: dat=%0d last=%0d", out_dat, out_last);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int k, input int n);
    start = 1'b1;
    cfg_k = K_W'(k);
    cfg_n = N_W'(n);
    cyc();
    start = 1'b0;
  endtask

  // Drive one product beat; checks the partial sum the MAC sees for that beat.
  task automatic beat(input acc_dat_t p, input acc_dat_t exp_acc);
    chk("mac_acc", 64'(mac_acc), 64'(exp_acc));
    mac_val = 1'b1;
    prod    = p;
    cyc();
    mac_val = 1'b0;
  endtask

  task automatic push(input acc_dat_t d, input logic l);
    exp_t e;
    e.dat  = d;
    e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input string name, input int exp_cyc);
    int n = 0;
    do begin
      cyc();
      n++;
    end while (!done && n < 64);
    chk(name, 64'(n), 64'(exp_cyc));
  endtask

  initial begin
    acc_dat_t ones;
    int       hs0;
    int       dc0;
    ones      = '1;
    out_ready = 1'b1;

    repeat (3) cyc();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_acc", 64'(mac_acc), 64'd0);

    // Basic K=3, N=2
    start_job(3, 2);
    chk("t1_busy", 64'(busy), 64'd1);
    push(27, 1'b0); push(9, 1'b1);
    beat(6, 0); beat(20, 6); beat(1, 26);
    beat(2, 0); beat(3, 2); beat(4, 5);
    chk("t1_valid_lat", 64'(out_valid), 64'd1);
    wait_done("t1_done_lat", 2);
    cyc();
    chk("t1_done_pulse", 64'(done), 64'd0);

    // Back-to-back, K=1
    start_job(1, 4);
    push(5, 1'b0); push(6, 1'b0); push(7, 1'b0); push(8, 1'b1);
    beat(5, 0); beat(6, 0); beat(7, 0); beat(8, 0);
    wait_done("t2_done_lat", 4);

    // Backpressure: ready 0,0,1,0,1
    start_job(3, 2);
    push(27, 1'b0); push(9, 1'b1);
    beat(6, 0); beat(20, 6); beat(1, 26);
    beat(2, 0); beat(3, 2);
    out_ready = 1'b0;
    beat(4, 5);
    hs0 = hs_cnt;
    cyc();
    chk("t3_hold0", 64'(out_dat), 64'd27);
    cyc();
    chk("t3_hold1", 64'(out_dat), 64'd27);
    out_ready = 1'b1;
    cyc();
    chk("t3_second", 64'(out_dat), 64'd9);
    chk("t3_last", 64'(out_last), 64'd1);
    out_ready = 1'b0;
    cyc();
    chk("t3_hold2", 64'(out_dat), 64'd9);
    chk("t3_nodone", 64'(done), 64'd0);
    out_ready = 1'b1;
    cyc();
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_hs", 64'(hs_cnt - hs0), 64'd2);

    // Edge configs
    start_job(4, 0);
    chk("t4_n0_done", 64'(done), 64'd1);
    chk("t4_n0_busy", 64'(busy), 64'd0);
    cyc();
    chk("t4_n0_busy2", 64'(busy), 64'd0);
    start_job(0, 1);
    push(9, 1'b1);
    beat(9, 0);
    wait_done("t4_k0_done", 1);
    start_job(1, 20);
    for (int i = 1; i <= 16; i++) begin
      push(acc_dat_t'(i), (i == 16));
      beat(acc_dat_t'(i), 0);
    end
    chk("t4_n20_drain", 64'(out_valid), 64'd1);
    wait_done("t4_n20_done", 16);

    // Protocol errors
    mac_val = 1'b1; prod = 77;
    cyc();
    mac_val = 1'b0;
    chk("t5_err_idle", 64'(err), 64'd1);
    start_job(1, 2);
    chk("t5_err_clr", 64'(err), 64'd0);
    push(11, 1'b0); push(12, 1'b1);
    start = 1'b1; cfg_k = K_W'(5); cfg_n = N_W'(1);
    beat(11, 0);
    start = 1'b0;
    out_ready = 1'b0;
    beat(12, 0);
    mac_val = 1'b1; prod = 99;
    cyc();
    mac_val = 1'b0;
    chk("t5_err_drain", 64'(err), 64'd1);
    chk("t5_dat_kept", 64'(out_dat), 64'd11);
    out_ready = 1'b1;
    wait_done("t5_done", 2);

    // Reset mid-job
    start_job(3, 1);
    beat(1, 0); beat(2, 1);
    dc0 = done_cnt;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_acc", 64'(mac_acc), 64'd0);
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_err", 64'(err), 64'd0);
    repeat (3) cyc();
    chk("t6_nodone", 64'(done_cnt - dc0), 64'd0);
    start_job(2, 1);
    push(7, 1'b1);
    beat(3, 0); beat(4, 3);
    wait_done("t6_done", 1);

    // Wrap-around of the running sum
    start_job(2, 1);
    push(0, 1'b1);
    beat(ones, 0); beat(1, ones);
    wait_done("wrap_done", 1);

    repeat (2) cyc();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
